// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// Serial-to-parallel receive stage of the UART controller. It consumes the
// 16x-oversampling tick from the baud rate generator, detects a start bit on a
// falling edge of the synchronized line, and samples every following bit at
// its centre. It assembles 5 to 8 data bits LSB first, checks the optional
// parity bit and one or two stop bits, then presents the byte and its status
// flags on a one-clock completion strobe.
//
// Ports
//   clk_i          system clock (baud generator domain)
//   rst_n_i        asynchronous active-low reset
//   ov_baud_rt_i   one-clock tick at 16x the baud rate
//   rx_i           asynchronous serial line, idle high
//   data_width_i   data bits: 00=5, 01=6, 10=7, 11=8
//   parity_en_i    1 = parity bit follows the data bits
//   parity_even_i  1 = even parity, 0 = odd parity
//   stop_bits_i    0 = one stop bit, 1 = two stop bits
//   rx_data_o      last received data, right-justified, upper bits zero
//   rx_done_o      one-clock strobe: frame complete, outputs updated
//   parity_error_o parity mismatch in the last frame
//   frame_error_o  a stop bit was sampled low in the last frame
//   rx_idle_o      1 while the receiver is idle
// -----------------------------------------------------------------------------
module uart_receiver (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ov_baud_rt_i,
    input  logic       rx_i,
    input  logic [1:0] data_width_i,
    input  logic       parity_en_i,
    input  logic       parity_even_i,
    input  logic       stop_bits_i,
    output logic [7:0] rx_data_o,
    output logic       rx_done_o,
    output logic       parity_error_o,
    output logic       frame_error_o,
    output logic       rx_idle_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    // Line synchronizer and edge history; all reset to the idle (high) level
    // so that reset release on an idle line never looks like a start bit.
    logic       rxMeta_q;
    logic       rxSync_q;
    logic       rxPrev_q;
    logic       fallEdge;

    state_t     state_q, state_d;
    logic [3:0] tickCnt_q, tickCnt_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic       stopCnt_q, stopCnt_d;

    // Frame format captured at start detection
    logic [1:0] cfgWidth_q, cfgWidth_d;
    logic       cfgParEn_q, cfgParEn_d;
    logic       cfgParEven_q, cfgParEven_d;
    logic       cfgStop2_q, cfgStop2_d;

    // Per-frame working state
    logic [7:0] shift_q, shift_d;
    logic       parAcc_q, parAcc_d;
    logic       parErr_q, parErr_d;
    logic       frmErr_q, frmErr_d;

    // Registered outputs
    logic [7:0] rxData_q, rxData_d;
    logic       rxDone_q, rxDone_d;
    logic       parityError_q, parityError_d;
    logic       frameError_q, frameError_d;
    logic       idle_q;

    logic       sampleMid;
    logic       sampleEnd;

    assign fallEdge  = rxPrev_q & ~rxSync_q;
    assign sampleMid = ov_baud_rt_i && (tickCnt_q == 4'd7);
    assign sampleEnd = ov_baud_rt_i && (tickCnt_q == 4'd15);

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx_i;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    // Next-state logic. The tick counter free-runs modulo 16 within a state,
    // so staying in STOP for a second stop bit naturally lands on the next
    // bit centre 16 ticks later. Any state change clears the counter.
    always_comb begin
        state_d       = state_q;
        tickCnt_d     = ov_baud_rt_i ? tickCnt_q + 4'd1 : tickCnt_q;
        bitCnt_d      = bitCnt_q;
        stopCnt_d     = stopCnt_q;
        cfgWidth_d    = cfgWidth_q;
        cfgParEn_d    = cfgParEn_q;
        cfgParEven_d  = cfgParEven_q;
        cfgStop2_d    = cfgStop2_q;
        shift_d       = shift_q;
        parAcc_d      = parAcc_q;
        parErr_d      = parErr_q;
        frmErr_d      = frmErr_q;
        rxData_d      = rxData_q;
        rxDone_d      = 1'b0;
        parityError_d = parityError_q;
        frameError_d  = frameError_q;

        unique case (state_q)
            IDLE: begin
                if (fallEdge) begin
                    state_d      = START;
                    cfgWidth_d   = data_width_i;
                    cfgParEn_d   = parity_en_i;
                    cfgParEven_d = parity_even_i;
                    cfgStop2_d   = stop_bits_i;
                    shift_d      = 8'h00;
                    parAcc_d     = 1'b0;
                    parErr_d     = 1'b0;
                    frmErr_d     = 1'b0;
                    bitCnt_d     = 3'd0;
                    stopCnt_d    = 1'b0;
                end
            end
            START: begin
                // A line that is high again at mid start bit was a glitch
                if (sampleMid) begin
                    state_d = rxSync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sampleEnd) begin
                    shift_d[bitCnt_q] = rxSync_q;
                    parAcc_d          = parAcc_q ^ rxSync_q;
                    // Index of the last data bit is 4..7, i.e. {1, width}
                    if (bitCnt_q == {1'b1, cfgWidth_q}) begin
                        state_d = cfgParEn_q ? PARITY : STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (sampleEnd) begin
                    // Even: error when total XOR is 1; odd: error when it is 0
                    parErr_d = parAcc_q ^ rxSync_q ^ ~cfgParEven_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (sampleEnd) begin
                    frmErr_d = frmErr_q | ~rxSync_q;
                    if (cfgStop2_q && !stopCnt_q) begin
                        stopCnt_d = 1'b1;
                    end else begin
                        // Outputs load together with the strobe so they are
                        // already valid while rx_done_o is high
                        state_d       = DONE;
                        rxDone_d      = 1'b1;
                        rxData_d      = shift_q;
                        parityError_d = parErr_q;
                        frameError_d  = frmErr_q | ~rxSync_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            tickCnt_d = 4'd0;
        end
    end

    // State, working and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            tickCnt_q     <= 4'd0;
            bitCnt_q      <= 3'd0;
            stopCnt_q     <= 1'b0;
            cfgWidth_q    <= 2'b00;
            cfgParEn_q    <= 1'b0;
            cfgParEven_q  <= 1'b0;
            cfgStop2_q    <= 1'b0;
            shift_q       <= 8'h00;
            parAcc_q      <= 1'b0;
            parErr_q      <= 1'b0;
            frmErr_q      <= 1'b0;
            rxData_q      <= 8'h00;
            rxDone_q      <= 1'b0;
            parityError_q <= 1'b0;
            frameError_q  <= 1'b0;
            idle_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            tickCnt_q     <= tickCnt_d;
            bitCnt_q      <= bitCnt_d;
            stopCnt_q     <= stopCnt_d;
            cfgWidth_q    <= cfgWidth_d;
            cfgParEn_q    <= cfgParEn_d;
            cfgParEven_q  <= cfgParEven_d;
            cfgStop2_q    <= cfgStop2_d;
            shift_q       <= shift_d;
            parAcc_q      <= parAcc_d;
            parErr_q      <= parErr_d;
            frmErr_q      <= frmErr_d;
            rxData_q      <= rxData_d;
            rxDone_q      <= rxDone_d;
            parityError_q <= parityError_d;
            frameError_q  <= frameError_d;
            idle_q        <= (state_d == IDLE);
        end
    end

    assign rx_data_o      = rxData_q;
    assign rx_done_o      = rxDone_q;
    assign parity_error_o = parityError_q;
    assign frame_error_o  = frameError_q;
    assign rx_idle_o      = idle_q;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//
// Self-checking bench for uart_receiver. Frames are built bit by bit from the
// requested format; the expected result of each frame comes from a small
// frame-level model (masked data, injected parity and stop errors).
// -----------------------------------------------------------------------------
module tb_uart_receiver;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic       tick = 1'b0;
    logic       rx;
    logic [1:0] width;
    logic       parEn;
    logic       parEven;
    logic       stopBits;
    logic [7:0] rxData;
    logic       rxDone;
    logic       parityError;
    logic       frameError;
    logic       rxIdle;

    int   vectors     = 0;
    int   miscompares = 0;
    int   div         = 4;
    bit   tickEn      = 1'b1;
    int   tickPhase   = 0;
    rec_t gotQ[$];
    rec_t got;
    rec_t exp;
    rec_t mon;
    int   wideStrobes = 0;
    bit   prevDone    = 1'b0;
    time  lastFallTime = 0;
    time  lastDoneTime = 0;

    uart_receiver dut (
        .clk_i          (clk),
        .rst_n_i        (rstN),
        .ov_baud_rt_i   (tick),
        .rx_i           (rx),
        .data_width_i   (width),
        .parity_en_i    (parEn),
        .parity_even_i  (parEven),
        .stop_bits_i    (stopBits),
        .rx_data_o      (rxData),
        .rx_done_o      (rxDone),
        .parity_error_o (parityError),
        .frame_error_o  (frameError),
        .rx_idle_o      (rxIdle)
    );

    always #5 clk = ~clk;

    // Oversampling tick: one clock high every div clocks, can be stalled
    always @(negedge clk) begin
        if (tickEn) begin
            if (tickPhase >= div - 1) begin
                tick = 1'b1;
                tickPhase = 0;
            end else begin
                tick = 1'b0;
                tickPhase++;
            end
        end else begin
            tick = 1'b0;
        end
    end

    // Collects every completion strobe and notes strobes wider than one clock
    always @(negedge clk) begin
        if (rxDone === 1'b1) begin
            mon.d  = rxData;
            mon.pe = parityError;
            mon.fe = frameError;
            gotQ.push_back(mon);
            lastDoneTime = $time;
            if (prevDone) wideStrobes++;
        end
        prevDone = (rxDone === 1'b1);
    end

    // Frame-level expectation: data masked to the configured width, parity
    // error only when parity is used and the sent bit was wrong, frame error
    // when any configured stop bit was low.
    function automatic rec_t model_frame(input logic [7:0] data, input logic [1:0] w,
                                         input logic pen, input logic parFlip,
                                         input logic stop2, input logic s1Low,
                                         input logic s2Low);
        rec_t r;
        int   n;
        n    = 5 + int'(w);
        r.d  = 8'(int'(data) % (1 << n));
        r.pe = pen & parFlip;
        r.fe = s1Low | (stop2 & s2Low);
        return r;
    endfunction

    task automatic idle_line(input int bits);
        rx = 1'b1;
        repeat (bits * 16 * div) @(negedge clk);
    endtask

    // Drives one complete frame; optionally scrambles the config inputs once
    // the start bit is under way, which must not affect the frame.
    task automatic send_frame(input logic [7:0] data, input logic [1:0] w,
                              input logic pen, input logic peven, input logic stop2,
                              input logic parFlip, input logic s1Low, input logic s2Low,
                              input logic scramble);
        int   bitClks;
        int   n;
        int   ones;
        logic pbit;
        bitClks = 16 * div;
        n = 5 + int'(w);
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(data[i]);
        pbit = peven ? (ones % 2 == 1) : (ones % 2 == 0);
        @(negedge clk);
        width    = w;
        parEn    = pen;
        parEven  = peven;
        stopBits = stop2;
        rx       = 1'b0;
        lastFallTime = $time;
        repeat (8) @(negedge clk);
        if (scramble) begin
            width    = 2'($urandom);
            parEn    = 1'($urandom);
            parEven  = 1'($urandom);
            stopBits = 1'($urandom);
        end
        repeat (bitClks - 8) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            rx = data[i];
            repeat (bitClks) @(negedge clk);
        end
        if (pen) begin
            rx = pbit ^ parFlip;
            repeat (bitClks) @(negedge clk);
        end
        rx = ~s1Low;
        repeat (bitClks) @(negedge clk);
        if (stop2) begin
            rx = ~s2Low;
            repeat (bitClks) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (rxData !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h, expected 00", rxData);
        end
        vectors++;
        if (rxDone !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_done: got %b, expected 0", rxDone);
        end
        vectors++;
        if (parityError !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_parity: got %b, expected 0", parityError);
        end
        vectors++;
        if (frameError !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_frame: got %b, expected 0", frameError);
        end
        vectors++;
        if (rxIdle !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: got %b, expected 1", rxIdle);
        end
        rstN = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1();
        div = 4;
        idle_line(1);
        exp = model_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (gotQ.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL 8n1_strobes: got %0d, expected 1", gotQ.size());
        end else begin
            got = gotQ.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL 8n1_frame: got d=%h pe=%b fe=%b, expected d=%h pe=%b fe=%b",
                         got.d, got.pe, got.fe, exp.d, exp.pe, exp.fe);
            end
        end
        gotQ.delete();
        vectors++;
        if (rxIdle !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL 8n1_idle: got %b, expected 1", rxIdle);
        end
    endtask

    task automatic test_parity();
        for (int k = 0; k < 2; k++) begin
            logic flip;
            flip = (k == 0);
            idle_line(1);
            exp = model_frame(8'h35, 2'b10, 1'b1, flip, 1'b0, 1'b0, 1'b0);
            send_frame(8'h35, 2'b10, 1'b1, 1'b1, 1'b0, flip, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (gotQ.size() != 1) begin
                miscompares++;
                $display("[TB] FAIL 7e1_strobes[%0d]: got %0d, expected 1", k, gotQ.size());
            end else begin
                got = gotQ.pop_front();
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL 7e1_frame[%0d]: got d=%h pe=%b fe=%b, expected d=%h pe=%b fe=%b",
                             k, got.d, got.pe, got.fe, exp.d, exp.pe, exp.fe);
                end
            end
            gotQ.delete();
        end
    endtask

    task automatic test_glitch();
        div = 4;
        idle_line(1);
        exp = model_frame(8'h6B, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h6B, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        gotQ.delete();
        @(negedge clk);
        rx = 1'b0;
        repeat (5 * div) @(negedge clk);
        rx = 1'b1;
        repeat (3 * 16 * div) @(negedge clk);
        vectors++;
        if (gotQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL glitch_strobes: got %0d, expected 0", gotQ.size());
        end
        vectors++;
        if (rxIdle !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL glitch_idle: got %b, expected 1", rxIdle);
        end
        vectors++;
        if (rxData !== exp.d) begin
            miscompares++;
            $display("[TB] FAIL glitch_data: got %h, expected %h", rxData, exp.d);
        end
        gotQ.delete();
    endtask

    task automatic test_break();
        div = 4;
        idle_line(1);
        exp = model_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (gotQ.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL break_strobes: got %0d, expected 1", gotQ.size());
        end else begin
            got = gotQ.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL break_frame: got d=%h pe=%b fe=%b, expected d=%h pe=%b fe=%b",
                         got.d, got.pe, got.fe, exp.d, exp.pe, exp.fe);
            end
        end
        gotQ.delete();
        rx = 1'b0;
        repeat (3 * 10 * 16 * div) @(negedge clk);
        vectors++;
        if (gotQ.size() != 0 || rxIdle !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL break_hold: got strobes=%0d idle=%b, expected strobes=0 idle=1",
                     gotQ.size(), rxIdle);
        end
        gotQ.delete();
        idle_line(1);
        exp = model_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (gotQ.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL break_recover_strobes: got %0d, expected 1", gotQ.size());
        end else begin
            got = gotQ.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL break_recover_frame: got d=%h pe=%b fe=%b, expected d=%h pe=%b fe=%b",
                         got.d, got.pe, got.fe, exp.d, exp.pe, exp.fe);
            end
        end
        gotQ.delete();
    endtask

    task automatic test_back_to_back();
        div = 4;
        idle_line(1);
        for (int k = 0; k < 2; k++) begin
            logic s1Low;
            s1Low = (k == 1);
            exp = model_frame(8'h13, 2'b00, 1'b1, 1'b0, 1'b1, s1Low, 1'b0);
            send_frame(8'h13, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, s1Low, 1'b0, 1'b0);
            vectors++;
            if (gotQ.size() != 1) begin
                miscompares++;
                $display("[TB] FAIL b2b_strobes[%0d]: got %0d, expected 1", k, gotQ.size());
            end else begin
                got = gotQ.pop_front();
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_frame[%0d]: got d=%h pe=%b fe=%b, expected d=%h pe=%b fe=%b",
                             k, got.d, got.pe, got.fe, exp.d, exp.pe, exp.fe);
                end
            end
            gotQ.delete();
        end
    endtask

    task automatic test_reset_midframe();
        int bitClks;
        div = 4;
        bitClks = 16 * div;
        idle_line(1);
        width = 2'b11; parEn = 1'b0; parEven = 1'b0; stopBits = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        repeat (bitClks) @(negedge clk);
        rx = 1'b1;
        repeat (3 * bitClks + bitClks / 2) @(negedge clk);
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        vectors++;
        if ({rxData, rxDone, parityError, frameError, rxIdle} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: got d=%h done=%b pe=%b fe=%b idle=%b, expected d=00 done=0 pe=0 fe=0 idle=1",
                     rxData, rxDone, parityError, frameError, rxIdle);
        end
        repeat (6 * bitClks) @(negedge clk);
        vectors++;
        if (gotQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_strobes: got %0d, expected 0", gotQ.size());
        end
        gotQ.delete();
        exp = model_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (gotQ.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL midreset_next_strobes: got %0d, expected 1", gotQ.size());
        end else begin
            got = gotQ.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL midreset_next_frame: got d=%h pe=%b fe=%b, expected d=%h pe=%b fe=%b",
                         got.d, got.pe, got.fe, exp.d, exp.pe, exp.fe);
            end
        end
        gotQ.delete();
    endtask

    // Stalled generator: the start edge is still seen, but the FSM must wait
    // for ticks; once they resume, a high line at mid start bit is a false start.
    task automatic test_stall();
        div = 4;
        idle_line(1);
        tickEn = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (rxIdle !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_started: got idle=%b, expected 0", rxIdle);
        end
        repeat (200) @(negedge clk);
        vectors++;
        if (rxIdle !== 1'b0 || gotQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL stall_hold: got idle=%b strobes=%0d, expected idle=0 strobes=0",
                     rxIdle, gotQ.size());
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        tickEn = 1'b1;
        repeat (16 * div) @(negedge clk);
        vectors++;
        if (rxIdle !== 1'b1 || gotQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL stall_false_start: got idle=%b strobes=%0d, expected idle=1 strobes=0",
                     rxIdle, gotQ.size());
        end
        gotQ.delete();
    endtask

    // Ticks on every clock: 2 synchronizer clocks, 1 clock into START, then
    // the tenth sample lands 152 ticks after START entry, strobe one clock later.
    task automatic test_timing();
        time delta;
        logic [7:0] data;
        div = 1;
        idle_line(2);
        data = 8'($urandom);
        exp = model_frame(data, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        lastDoneTime = 0;
        send_frame(data, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        delta = lastDoneTime - lastFallTime;
        vectors++;
        if (delta < 1540 || delta > 1560) begin
            miscompares++;
            $display("[TB] FAIL timing_latency: got %0t, expected 1540..1560", delta);
        end
        vectors++;
        if (gotQ.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL timing_strobes: got %0d, expected 1", gotQ.size());
        end else begin
            got = gotQ.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL timing_frame: got d=%h pe=%b fe=%b, expected d=%h pe=%b fe=%b",
                         got.d, got.pe, got.fe, exp.d, exp.pe, exp.fe);
            end
        end
        gotQ.delete();
    endtask

    task automatic test_random();
        logic [7:0] data;
        logic [1:0] w;
        logic       pen, peven, stop2, flip, s1Low, s2Low, scr;
        int         gap;
        bit         lastLow;
        lastLow = 1'b0;
        for (int k = 0; k < 16; k++) begin
            div   = $urandom_range(1, 4);
            data  = 8'($urandom);
            w     = 2'($urandom);
            pen   = 1'($urandom);
            peven = 1'($urandom);
            stop2 = 1'($urandom);
            flip  = pen & ($urandom_range(0, 2) == 0);
            s1Low = ($urandom_range(0, 3) == 0);
            s2Low = stop2 & ($urandom_range(0, 3) == 0);
            scr   = 1'($urandom);
            gap   = $urandom_range(0, 2);
            if (lastLow && gap == 0) gap = 1;
            if (gap > 0) idle_line(gap);
            exp = model_frame(data, w, pen, flip, stop2, s1Low, s2Low);
            send_frame(data, w, pen, peven, stop2, flip, s1Low, s2Low, scr);
            lastLow = stop2 ? s2Low : s1Low;
            vectors++;
            if (gotQ.size() != 1) begin
                miscompares++;
                $display("[TB] FAIL random_strobes[%0d]: got %0d, expected 1", k, gotQ.size());
            end else begin
                got = gotQ.pop_front();
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL random_frame[%0d]: got d=%h pe=%b fe=%b, expected d=%h pe=%b fe=%b",
                             k, got.d, got.pe, got.fe, exp.d, exp.pe, exp.fe);
                end
            end
            gotQ.delete();
        end
        idle_line(1);
    endtask

    task automatic test_strobe_width();
        vectors++;
        if (wideStrobes != 0) begin
            miscompares++;
            $display("[TB] FAIL strobe_width: got %0d wide strobes, expected 0", wideStrobes);
        end
    endtask

    initial begin
        rstN     = 1'b0;
        rx       = 1'b1;
        width    = 2'b11;
        parEn    = 1'b0;
        parEven  = 1'b0;
        stopBits = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_midframe();
        test_stall();
        test_timing();
        test_random();
        test_strobe_width();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receive stage of the UART controller, directly downstream of the baud rate generator. It consumes the 16x-oversampling tick, detects a start bit and samples each bit at its centre. It assembles 5 to 8 data bits, checks optional parity and the stop bit(s), then presents the received byte with status flags to the register/FIFO layer on a one-cycle completion strobe.

## Interface
Parameters: none. Frame format is run-time configurable.

- clk_i  input  1  system clock, same domain as the baud rate generator
- rst_n_i  input  1  reset, asynchronous, active-low
- ov_baud_rt_i  input  1  one-clk tick at 16x baud rate (generator output)
- rx_i  input  1  asynchronous serial line, idle high
- data_width_i  input  2  data bits: 00=5, 01=6, 10=7, 11=8
- parity_en_i  input  1  1 = parity bit present after data
- parity_even_i  input  1  1 = even parity, 0 = odd
- stop_bits_i  input  1  0 = one stop bit, 1 = two stop bits
- rx_data_o  output  8  last received data, right-justified, unused upper bits 0
- rx_done_o  output  1  one-clk strobe: frame complete, outputs updated
- parity_error_o  output  1  parity mismatch in last frame (0 when parity disabled)
- frame_error_o  output  1  a stop bit sampled low in last frame
- rx_idle_o  output  1  1 while FSM is in IDLE

## Operation
- rx_i passes through a 2-FF synchronizer. Both flops reset to 1. All logic uses the synchronized value rxs.
- Start detection uses a falling edge: previous rxs=1 and current rxs=0. A held-low line (break) therefore cannot retrigger a frame.
- Config inputs are latched at start detection. Changes during a frame have no effect until the next frame.
- There is a 4-bit tick counter tcnt, cleared on every state entry. It advances only on cycles where ov_baud_rt_i=1.
- FSM states and transitions:
  - IDLE: wait for a falling edge, then go to START.
  - START: on the 8th tick (tcnt=7 with tick), sample rxs.
    - If rxs=1: false start, go to IDLE with no strobe and outputs unchanged.
    - If rxs=0: go to DATA. This sample point is bit centre.
  - DATA: sample rxs on every 16th tick (tcnt=15 with tick), LSB first. After N bits (N from data_width_i), go to PARITY if parity is enabled, else STOP.
  - PARITY: sample on the 16th tick. The error condition is:
    - even parity: XOR of data bits and parity bit = 1
    - odd parity: XOR of data bits and parity bit = 0
  - STOP: sample on the 16th tick. A low sample sets the frame-error flag. If two stop bits are configured, sample again 16 ticks later; either sample low sets the flag. After the last stop sample, go to DONE.
  - DONE: lasts one clk. In this cycle:
    - drive rx_done_o=1
    - load rx_data_o, parity_error_o and frame_error_o
    - go to IDLE
- IDLE is re-entered at mid-stop-bit. This leaves half a bit for resynchronisation on back-to-back frames.
- rx_data_o and the error outputs hold their values until the next DONE. A false start does not change them.
- A frame error still delivers the data with rx_done_o.

## Timing
- Reset values: rx_data_o=0, rx_done_o=0, parity_error_o=0, frame_error_o=0, rx_idle_o=1. The FSM resets to IDLE and tcnt to 0.
- Reset asserted mid-frame aborts the frame immediately, with no strobe. After release, the block waits for a fresh falling edge.
- From the rx_i falling edge, the edge is detected 2–3 clk later (synchronizer latency).
- Sample k (k=0 is start) occurs on the tick numbered 8+16k after START entry.
- rx_done_o is asserted on the clk after the final stop-bit sample tick and lasts exactly one clk.
- Ticks arriving on consecutive clocks are legal (divisor 0). Each tick advances tcnt by exactly 1.
- Without ticks, the FSM holds state indefinitely (generator stalled).
- rx_idle_o is a registered decode of state. It falls the clk after start detection and rises the clk after DONE.

## Test plan
- 8N1, ov tick every 4 clk, send 0xA5 → one rx_done_o pulse, rx_data_o=0xA5, both errors 0, rx_idle_o back to 1.
- 7E1, send 0x35 with parity bit forced to 1 (correct is 0) → rx_data_o=0x35, parity_error_o=1, frame_error_o=0. Resend with correct parity → parity_error_o=0.
- Glitch: rx_i low for 5 ticks, then high → no rx_done_o, FSM back in IDLE, rx_data_o unchanged from previous frame.
- 8N1, send 0x3C with stop bit low, then hold rx_i low for 3 frames → one strobe with frame_error_o=1 and rx_data_o=0x3C. No further strobes until rx_i rises and a new falling edge occurs.
- 5-bit, odd parity, 2 stop bits, send 0x13 back-to-back twice with the second frame's first stop bit low → two strobes, both rx_data_o=0x13, frame_error_o=0 then 1.
- Assert rst_n_i during the 4th data bit of 0xFF, release, then send 0x81 → no strobe for the aborted frame, all outputs at reset values, then rx_data_o=0x81 with no errors.
